// File: rtl/md5_main.sv
// md5_main: MD5 compression core, one step per clock, chaining state kept across blocks
module md5_main (
  input  logic         in_clk,
  input  logic         rst_n,
  input  logic         start_cope,
  input  logic         start_block,
  input  logic [511:0] copedata,
  output logic         copefinish,
  output logic [127:0] MD5code,
  input  logic         over
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
  localparam logic [31:0] K_TAB [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  // shift amounts indexed by {quarter, step mod 4}
  localparam logic [4:0] S_TAB [0:15] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };
  state_t state, state_nx;
  logic [5:0] cnt;
  logic [31:0] a, b, c, d;
  logic [127:0] base, h;
  logic [511:0] blk;
  logic [1:0] q;
  logic [3:0] g;
  logic [4:0] s;
  logic [31:0] f, m, sum, rot, tmp;
  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
  // state register
  always_ff @(posedge in_clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: start only from idle when no digest capture is requested
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = (start_block && !over) ? ROUND : IDLE;
    else if (state == ROUND) state_nx = (cnt == 6'd63) ? DONE : ROUND;
    else state_nx = IDLE;
  end
  // one MD5 step: round function, message word select and rotate
  always_comb begin
    q = cnt[5:4];
    f = q == 2'd0 ? (b & c) | (~b & d) :
        q == 2'd1 ? (d & b) | (~d & c) :
        q == 2'd2 ? b ^ c ^ d : c ^ (b | ~d);
    g = q == 2'd0 ? cnt[3:0] :
        q == 2'd1 ? cnt[3:0] * 4'd5 + 4'd1 :
        q == 2'd2 ? cnt[3:0] * 4'd3 + 4'd5 : cnt[3:0] * 4'd7;
    s = S_TAB[{q, cnt[1:0]}];
    m = blk[32*g +: 32];
    sum = a + f + K_TAB[cnt] + m;
    rot = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
    tmp = b + rot;
  end
  // datapath: block latch, working variables, chaining state, digest capture
  always_ff @(posedge in_clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      {a, b, c, d} <= '0;
      base <= '0;
      h <= IV;
      blk <= '0;
      copefinish <= 1'b0;
      MD5code <= '0;
    end else begin
      copefinish <= state == DONE;
      if (state == IDLE && over)
        MD5code <= {bswap(h[127:96]), bswap(h[95:64]), bswap(h[63:32]), bswap(h[31:0])};
      if (state == IDLE && start_block && !over) begin
        blk <= copedata;
        base <= start_cope ? IV : h;
        {a, b, c, d} <= start_cope ? IV : h;
        cnt <= '0;
      end
      if (state == ROUND) begin
        {a, b, c, d} <= {d, tmp, b, c};
        cnt <= cnt + 6'd1;
      end
      if (state == DONE)
        h <= {base[127:96] + a, base[95:64] + b, base[63:32] + c, base[31:0] + d};
    end
endmodule

// File: tb/tb_md5_main.sv
// tb_md5_main: directed known-answer checks for the MD5 compression core
module tb_md5_main;
  logic in_clk = 0, rst_n = 0, start_cope = 0, start_block = 0, over = 0;
  logic [511:0] copedata = '0;
  logic copefinish;
  logic [127:0] MD5code;
  int checks = 0, errors = 0;
  int first, pulses;
  logic [127:0] saved;
  localparam logic [127:0] IV_DIG = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] ABC = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] DIG80 = 128'h57edf4a22be3c955ac49da2e2107b67a;
  md5_main dut (.in_clk(in_clk), .rst_n(rst_n), .start_cope(start_cope), .start_block(start_block),
                .copedata(copedata), .copefinish(copefinish), .MD5code(MD5code), .over(over));
  always #5 in_clk = ~in_clk;
  task automatic tick;
    @(posedge in_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic logic [511:0] mk(input string txt, input bit pad, input int bits);
    logic [511:0] r = '0;
    for (int j = 0; j < txt.len(); j++) r[8*j +: 8] = txt[j];
    if (pad) begin
      r[8*txt.len() +: 8] = 8'h80;
      r[448 +: 64] = 64'(bits);
    end
    return r;
  endfunction
  // start a block, then run a fixed window counting copefinish pulses
  task automatic run_block(input logic [511:0] data, input logic cope, input int dis_at,
                           input int over_at, output int fst, output int np);
    copedata = data;
    start_cope = cope;
    start_block = 1;
    tick;
    start_block = 0;
    start_cope = 1'($urandom);
    fst = -1;
    np = 0;
    for (int t = 1; t <= 75; t++) begin
      if (t == dis_at) begin
        start_block = 1;
        copedata = {16{$urandom}};
      end
      if (t == dis_at + 3) start_block = 0;
      over = (t == over_at);
      tick;
      over = 0;
      if (copefinish) begin
        np++;
        if (fst < 0) fst = t;
      end
    end
  endtask
  task automatic over_pulse(input logic sb);
    over = 1;
    start_block = sb;
    tick;
    over = 0;
    start_block = 0;
  endtask
  initial begin
    #12;
    chk("reset_md5code", MD5code, '0);
    chk("reset_copefinish", 128'(copefinish), 0);
    rst_n = 1;
    tick;
    over_pulse(0);
    chk("iv_digest", MD5code, IV_DIG);
    run_block(mk("", 1, 0), 1, 0, 0, first, pulses);
    chk("empty_latency", 128'(first), 65);
    chk("empty_pulses", 128'(pulses), 1);
    over_pulse(1);
    chk("empty_digest", MD5code, EMPTY);
    pulses = 0;
    for (int t = 0; t < 70; t++) begin
      tick;
      if (copefinish) pulses++;
    end
    chk("over_blocks_start", 128'(pulses), 0);
    run_block(mk("abc", 1, 24), 1, 0, 10, first, pulses);
    chk("over_busy_ignored", MD5code, EMPTY);
    over_pulse(0);
    chk("abc_digest", MD5code, ABC);
    run_block(mk("abc", 1, 24), 1, 30, 0, first, pulses);
    chk("disturb_pulses", 128'(pulses), 1);
    over_pulse(0);
    chk("disturb_digest", MD5code, ABC);
    run_block(mk("1234567890123456789012345678901234567890123456789012345678901234", 0, 0), 1, 0, 0, first, pulses);
    run_block(mk("5678901234567890", 1, 640), 0, 0, 0, first, pulses);
    over_pulse(0);
    chk("two_block_digest", MD5code, DIG80);
    saved = MD5code;
    run_block(mk("5678901234567890", 1, 640), 0, 0, 0, first, pulses);
    over_pulse(0);
    checks++;
    assert (MD5code !== saved) else begin
      errors++;
      $error("FAIL chain_changes: got %h want anything but %h", MD5code, saved);
    end
    copedata = mk("abc", 1, 24);
    start_cope = 1;
    start_block = 1;
    tick;
    start_block = 0;
    repeat (20) tick;
    #2 rst_n = 0;
    #2;
    chk("abort_md5code", MD5code, '0);
    chk("abort_copefinish", 128'(copefinish), 0);
    rst_n = 1;
    pulses = 0;
    for (int t = 0; t < 70; t++) begin
      tick;
      if (copefinish) pulses++;
    end
    chk("abort_no_pulse", 128'(pulses), 0);
    over_pulse(0);
    chk("abort_iv_digest", MD5code, IV_DIG);
    run_block(mk("abc", 1, 24), 1, 0, 0, first, pulses);
    over_pulse(0);
    chk("fresh_abc_digest", MD5code, ABC);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
